// File: rtl/uart_byte_tx.sv
// uart_byte_tx: single-byte 8N1 UART serializer, LSB first.
// A frame starts only on a 0->1 transition of tx_start seen while idle, so a
// requester that keeps start high across the end of a frame never retriggers.
module uart_byte_tx #(
  parameter int unsigned CLK_FREQ     = 100_000_000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       txd
);

  // A bit period shorter than two cycles cannot be represented by the counter.
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_byte_tx: CLKS_PER_BIT must be >= 2");
  end

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic             start_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic accept;
  logic bit_end;

  assign accept  = tx_start && !start_q && (state_q == S_IDLE);
  assign bit_end = (cnt_q == CNT_LAST);

  // Next-state logic: the line value for the next cycle is computed here so
  // that txd, tx_busy and tx_done all come straight from flops.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          shift_d = tx_data;
          cnt_d   = '0;
          idx_d   = '0;
          txd_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          txd_d   = shift_q[0];
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = S_STOP;
          end else begin
            // Bit 1 of the current shift value is the next bit on the line.
            shift_d = {1'b0, shift_q[7:1]};
            idx_d   = idx_q + 3'd1;
            txd_d   = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        txd_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any frame and idles the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= tx_start;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign txd     = txd_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
// tb_uart_byte_tx: checks uart_byte_tx cycle by cycle against the expected
// 8N1 waveform of each byte, built as the 10-bit frame {stop, data, start}.
module tb_uart_byte_tx;

  localparam int CPB = 10;  // 1000 Hz / 100 baud

  logic       clk;
  logic       rst_n;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;
  logic       txd;

  int checks;
  int failures;

  uart_byte_tx #(
    .CLK_FREQ(1000),
    .BAUD    (100)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx_busy (tx_busy),
    .tx_done (tx_done),
    .txd     (txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Runs one expected frame of byte d and checks every cycle from the first
  // cycle after acceptance through 'extra' idle cycles after busy falls.
  //   hold     : cycles start stays high (<0: drop in the cycle after busy falls)
  //   pulse_at : cycle of a one-cycle start pulse with pulse_d (<0: none)
  //   chg_at   : cycle at which tx_data changes to chg_d (<0: none)
  task automatic frame(input bit raise, input logic [7:0] d, input int hold,
                       input int pulse_at, input logic [7:0] pulse_d,
                       input int chg_at, input logic [7:0] chg_d,
                       input int extra);
    logic [9:0] frm;
    logic       exp_txd;
    int         bi;
    int         total;
    int         errs0;
    frm   = {1'b1, d, 1'b0};
    total = 10 * CPB + 1 + extra;
    errs0 = failures;
    if (raise) begin
      @(negedge clk);
      tx_start = 1'b1;
      tx_data  = d;
    end
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      bi = c / CPB;
      exp_txd = (c < 10 * CPB) ? frm[bi[3:0]] : 1'b1;
      chk($sformatf("txd byte=%02h c=%0d", d, c), txd, exp_txd);
      chk($sformatf("busy byte=%02h c=%0d", d, c), tx_busy, c < 10 * CPB);
      chk($sformatf("done byte=%02h c=%0d", d, c), tx_done, c == 10 * CPB);
      if (hold > 0 && c + 1 == hold) tx_start = 1'b0;
      if (hold < 0 && c == 10 * CPB) tx_start = 1'b0;
      if (c == pulse_at) begin
        tx_start = 1'b1;
        tx_data  = pulse_d;
      end
      if (pulse_at >= 0 && c == pulse_at + 1) tx_start = 1'b0;
      if (c == chg_at) tx_data = chg_d;
    end
    $display("frame byte=%02h hold=%0d pulse_at=%0d chg_at=%0d extra=%0d errors=%0d",
             d, hold, pulse_at, chg_at, extra, failures - errs0);
  endtask

  logic [7:0] msg [6];
  logic [7:0] rd;

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    msg[0] = 8'h31; msg[1] = 8'h78; msg[2] = 8'h32;
    msg[3] = 8'h3A; msg[4] = 8'h33; msg[5] = 8'h0A;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset txd", txd, 1'b1);
    chk("reset busy", tx_busy, 1'b0);
    chk("reset done", tx_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle txd", txd, 1'b1);
    chk("idle busy", tx_busy, 1'b0);
    $display("reset released, line idle");

    // Single frame 0x41, one-cycle start pulse
    frame(1'b1, 8'h41, 1, -1, 8'h00, -1, 8'h00, 20);

    // Start held high for 300 cycles: exactly one frame
    frame(1'b1, 8'h55, 300, -1, 8'h00, -1, 8'h00, 250);

    // Display-style handshake over six bytes
    for (int i = 0; i < 6; i++)
      frame(1'b1, msg[i], -1, -1, 8'h00, -1, 8'h00, (i == 5) ? 30 : 0);

    // Rising edge while busy is ignored
    frame(1'b1, 8'hA5, 1, 40, 8'hFF, -1, 8'h00, 60);

    // tx_data change mid-frame has no effect
    frame(1'b1, 8'h0F, 1, -1, 8'h00, 20, 8'hF0, 10);

    // Randomized bytes, hold lengths, data changes and idle gaps
    for (int i = 0; i < 8; i++) begin
      rd = 8'($urandom);
      frame(1'b1, rd, $urandom_range(1, 6), -1, 8'h00,
            $urandom_range(0, 99), 8'($urandom), $urandom_range(0, 5));
    end

    // Reset in the middle of a frame (data bit 4 of 0x00 is on the line)
    @(negedge clk);
    tx_start = 1'b1;
    tx_data  = 8'h00;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (55) @(negedge clk);
    chk("pre-reset txd", txd, 1'b0);
    chk("pre-reset busy", tx_busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset txd", txd, 1'b1);
    chk("midreset busy", tx_busy, 1'b0);
    chk("midreset done", tx_done, 1'b0);
    $display("reset asserted mid-frame");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post-reset txd", txd, 1'b1);
    chk("post-reset busy", tx_busy, 1'b0);
    rd = 8'($urandom);
    frame(1'b1, rd, 2, -1, 8'h00, -1, 8'h00, 10);

    // Start already high when reset is released counts as a rising edge
    @(negedge clk);
    rst_n    = 1'b0;
    tx_start = 1'b1;
    tx_data  = 8'hC3;
    @(negedge clk);
    rst_n = 1'b1;
    frame(1'b0, 8'hC3, 3, -1, 8'h00, -1, 8'h00, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_byte_tx.md
# uart_byte_tx

Single-byte 8N1 UART serializer that drives the board TX pin for the matrix-info, matrix-print and result-display blocks. It accepts a byte on a rising edge of `tx_start`, shifts it out LSB-first at a fixed baud rate and signals completion through `tx_busy`/`tx_done`. The display blocks use a level-style handshake: they hold start high, wait for busy to rise, then wait for busy to fall. The block must be immune to start still being high after a frame ends.

## Interface
- `CLK_FREQ`, default 100_000_000: system clock frequency in Hz.
- `BAUD`, default 115200: line rate in bit/s.
- `CLKS_PER_BIT`, default CLK_FREQ/BAUD (integer division, 868 at defaults): cycles per bit. It must be ≥ 2; an elaboration-time check enforces this.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `tx_start`  in  1  send request. A byte is accepted only on a rising edge.
- `tx_data`  in  8  byte to send, sampled in the accept cycle.
- `tx_busy`  out  1  high for the full frame.
- `tx_done`  out  1  one-cycle pulse in the cycle `tx_busy` falls.
- `txd`  out  1  serial line; idles high.

## Operation
- **Reset values:** `txd`=1, `tx_busy`=0, `tx_done`=0. The start-edge register `start_q` resets to 0 and the FSM resets to S_IDLE. The baud counter and bit index reset to 0.
- **Edge detect:**
  - `start_q` <= `tx_start` every cycle, in every state.
  - The accept condition is `tx_start && !start_q && state==S_IDLE`.
  - If `tx_start` is high at reset release, this counts as a rising edge and starts a frame.
- **Accept:** latch `tx_data` into the shift register and go to S_START.
- **S_START:** `txd`=0 for CLKS_PER_BIT cycles, then go to S_DATA with bit index 0.
- **S_DATA:** `txd`=shift[0]. Every CLKS_PER_BIT cycles, shift right and increment the index. After the bit with index 7, go to S_STOP.
- **S_STOP:** `txd`=1 for CLKS_PER_BIT cycles. Then go to S_IDLE, clear `tx_busy` and pulse `tx_done`.
- **Baud counter:** width is clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary, and is cleared on accept.
- **Ignored requests:**
  - A rising edge of `tx_start` while busy is ignored, not queued.
  - A level-high `tx_start` never retriggers, including when it stays high across the end of a frame.
- **Data stability:** changes on `tx_data` after the accept cycle have no effect on the frame in flight.
- **Reset mid-frame:** all outputs return to their reset values immediately (asynchronous). The frame is abandoned and the line goes high.

## Timing
- **Accept:** the edge is sampled at clock edge k.
  - From edge k+1: `tx_busy`=1 and `txd`=0, both registered.
- **Frame length:** exactly 10×CLKS_PER_BIT cycles (start bit, 8 data bits, 1 stop bit).
  - `tx_busy` is high for exactly 10×CLKS_PER_BIT cycles.
  - It falls at edge k+1+10×CLKS_PER_BIT.
  - `tx_done` is high for that one cycle only.
- **Earliest next accept:** the first cycle in S_IDLE in which `tx_start` shows a 0→1 transition. With a requester that drops start in the cycle after busy falls and re-raises it one cycle later, the idle gap between frames is ≥ 2 cycles.
- **Bit order:** LSB first. Each bit is held exactly CLKS_PER_BIT cycles, with no fractional-bit correction.

## Test plan
- **Single frame** (CLK_FREQ=1000, BAUD=100, so CLKS_PER_BIT=10): pulse start with 0x41.
  - `txd` reads 0,1,0,0,0,0,0,1,0,1, each value for 10 cycles.
  - `tx_busy` is high for 100 cycles; `tx_done` is one pulse at busy fall.
- **Held start:** raise start with 0x55 and keep it high for 300 cycles.
  - Exactly one frame is sent; `txd` stays high after the stop bit.
- **Display-style handshake:** start stays high until the cycle after busy falls, then drops; repeat for "1","x","2",":","3",0x0A.
  - Six frames with the correct bytes; no duplicates and no drops.
- **Edge during busy:** pulse start with 0xA5, then pulse again with 0xFF at cycle 40.
  - Only 0xA5 is transmitted; no second frame follows.
- **Data change:** change `tx_data` from 0x0F to 0xF0 at cycle 20 of a frame.
  - The line still carries 0x0F.
- **Reset mid-frame:** assert `rst_n`=0 at cycle 55.
  - `txd`=1 and `tx_busy`=0 immediately.
  - After release, a new start edge produces a clean full frame.
